// File: rtl/apb2axi_lite_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb2axi_lite_bridge
// Brief    : 32-bit APB slave to 64-bit AXI4-Lite master bridge. One transfer
//            at a time; the APB access phase is held with pready until the
//            AXI response returns. APB data is steered onto the 64-bit lane
//            selected by paddr[2].
// Revision : 1.0 - initial release
// ============================================================================
module apb2axi_lite_bridge #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // APB slave
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]           pwdata_i,
    input  logic [3:0]            pstrb_i,
    input  logic [2:0]            pprot_i,
    output logic                  pready_o,
    output logic [31:0]           prdata_o,
    output logic                  pslverr_o,
    // AXI4-Lite write address
    output logic [ADDR_WIDTH-1:0] aw_addr_o,
    output logic [2:0]            aw_prot_o,
    output logic                  aw_valid_o,
    input  logic                  aw_ready_i,
    // AXI4-Lite write data
    output logic [63:0]           w_data_o,
    output logic [7:0]            w_strb_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    // AXI4-Lite write response
    input  logic [1:0]            b_resp_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    // AXI4-Lite read address
    output logic [ADDR_WIDTH-1:0] ar_addr_o,
    output logic [2:0]            ar_prot_o,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    // AXI4-Lite read data
    input  logic [63:0]           r_data_i,
    input  logic [1:0]            r_resp_i,
    input  logic                  r_valid_i,
    output logic                  r_ready_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_strb;
    logic [2:0]            r_prot;

    logic                  r_aw_sent;
    logic                  r_w_sent;
    logic [31:0]           r_prdata;
    logic                  r_pslverr;

    logic                  w_setup;
    logic                  w_aw_fire;
    logic                  w_w_fire;

    // Setup phase of a new APB transfer; only honoured in IDLE.
    assign w_setup   = psel_i && !penable_i;
    assign w_aw_fire = aw_valid_o && aw_ready_i;
    assign w_w_fire  = w_valid_o && w_ready_i;

    // Request fields are frozen from setup until the FSM is back in IDLE,
    // so AXI payload never changes while a valid is up.
    assign aw_addr_o = r_addr;
    assign ar_addr_o = r_addr;
    assign aw_prot_o = r_prot;
    assign ar_prot_o = r_prot;
    assign w_data_o  = {r_wdata, r_wdata};
    assign w_strb_o  = r_addr[2] ? {r_strb, 4'b0000} : {4'b0000, r_strb};
    assign prdata_o  = r_prdata;
    assign pslverr_o = r_pslverr;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_next_state = pwrite_i ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if ((r_aw_sent || w_aw_fire) && (r_w_sent || w_w_fire)) begin
                    w_next_state = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (b_valid_i) begin
                    w_next_state = S_DONE;
                end
            end
            S_RD_REQ: begin
                if (ar_ready_i) begin
                    w_next_state = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (r_valid_i) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake-facing outputs, decoded purely from registered state.
    always_comb begin
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        b_ready_o  = 1'b0;
        ar_valid_o = 1'b0;
        r_ready_o  = 1'b0;
        pready_o   = 1'b0;
        case (r_state)
            S_WR_REQ: begin
                aw_valid_o = !r_aw_sent;
                w_valid_o  = !r_w_sent;
            end
            S_WR_RESP: b_ready_o  = 1'b1;
            S_RD_REQ:  ar_valid_o = 1'b1;
            S_RD_RESP: r_ready_o  = 1'b1;
            S_DONE:    pready_o   = 1'b1;
            default:   ;
        endcase
    end

    // Capture the APB request at setup.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
        end else if ((r_state == S_IDLE) && w_setup) begin
            r_addr  <= paddr_i;
            r_wdata <= pwdata_i;
            r_strb  <= pstrb_i;
            r_prot  <= pprot_i;
        end
    end

    // Per-channel sent flags so AW and W can complete in any order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_aw_sent <= 1'b0;
            r_w_sent  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_aw_sent <= 1'b0;
            r_w_sent  <= 1'b0;
        end else begin
            if (w_aw_fire) r_aw_sent <= 1'b1;
            if (w_w_fire)  r_w_sent  <= 1'b1;
        end
    end

    // Register the response; bit 1 of resp flags both SLVERR and DECERR.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else if ((r_state == S_WR_RESP) && b_valid_i) begin
            r_pslverr <= b_resp_i[1];
        end else if ((r_state == S_RD_RESP) && r_valid_i) begin
            r_prdata  <= r_addr[2] ? r_data_i[63:32] : r_data_i[31:0];
            r_pslverr <= r_resp_i[1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb2axi_lite_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb2axi_lite_bridge
// Brief    : Directed and randomised-backpressure bench for the APB to
//            AXI4-Lite bridge, with a behavioural AXI slave and word model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb2axi_lite_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
    logic [31:0] paddr_i = '0, pwdata_i = '0;
    logic [3:0]  pstrb_i = '0;
    logic [2:0]  pprot_i = '0;
    logic        pready_o, pslverr_o;
    logic [31:0] prdata_o;
    logic [31:0] aw_addr_o, ar_addr_o;
    logic [2:0]  aw_prot_o, ar_prot_o;
    logic        aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        aw_ready_i = 1'b0, w_ready_i = 1'b0, ar_ready_i = 1'b0;
    logic        b_valid_i = 1'b0, r_valid_i = 1'b0;
    logic [1:0]  b_resp_i = '0, r_resp_i = '0;
    logic [63:0] r_data_i = '0;

    apb2axi_lite_bridge #(.ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i), .pprot_i(pprot_i),
        .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
        .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    // ---------------- behavioural AXI4-Lite slave ----------------
    int          aw_cfg = 0, w_cfg = 0, b_cfg = 0, ar_cfg = 0, r_cfg = 0;
    logic        rnd_mode = 1'b0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    int          aw_cnt, aw_cur, w_cnt, w_cur, ar_cnt, ar_cur, b_cnt, b_cur, r_cnt, r_cur;
    logic        aw_vq, w_vq, ar_vq, b_hq, r_hq, aw_got, w_got, b_pend, r_pend;
    logic [31:0] p_aw_addr, p_ar_addr, cap_awaddr, cap_araddr;
    logic [2:0]  p_aw_prot, p_ar_prot, cap_awprot, cap_arprot;
    logic [63:0] p_w_data, cap_wdata;
    logic [7:0]  p_w_strb, cap_wstrb;
    logic [63:0] mem [0:255];
    logic [31:0] ref_mem [0:511];

    function automatic int pick(input int cfg);
        return rnd_mode ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
            aw_vq = 0; w_vq = 0; ar_vq = 0; b_hq = 0; r_hq = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        end else begin
            // handshakes completed at the preceding rising edge, or held payload
            if (aw_vq && aw_ready_i) begin
                aw_got = 1; cap_awaddr = p_aw_addr; cap_awprot = p_aw_prot; aw_ready_i = 0; aw_cnt = 0;
            end else if (aw_vq) begin
                chk("aw_hold", aw_valid_o, 1);
                chk("aw_stable", {aw_addr_o, aw_prot_o}, {p_aw_addr, p_aw_prot});
            end
            if (w_vq && w_ready_i) begin
                w_got = 1; cap_wdata = p_w_data; cap_wstrb = p_w_strb; w_ready_i = 0; w_cnt = 0;
            end else if (w_vq) begin
                chk("w_hold", w_valid_o, 1);
                chk("w_stable", {w_data_o, w_strb_o}, {p_w_data, p_w_strb});
            end
            if (ar_vq && ar_ready_i) begin
                cap_araddr = p_ar_addr; cap_arprot = p_ar_prot; ar_ready_i = 0; ar_cnt = 0;
                r_pend = 1; r_cnt = 0;
            end else if (ar_vq) begin
                chk("ar_hold", ar_valid_o, 1);
                chk("ar_stable", {ar_addr_o, ar_prot_o}, {p_ar_addr, p_ar_prot});
            end
            if (b_hq) b_valid_i = 0;
            if (r_hq) r_valid_i = 0;
            if (aw_got && w_got) begin
                for (int i = 0; i < 8; i++)
                    if (cap_wstrb[i]) mem[cap_awaddr[10:3]][8*i +: 8] = cap_wdata[8*i +: 8];
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
            end
            // ready / response generation with programmable delay
            if (aw_valid_o && !aw_ready_i) begin
                if (aw_cnt == 0) aw_cur = pick(aw_cfg);
                if (aw_cnt >= aw_cur) aw_ready_i = 1; else aw_cnt++;
            end
            if (w_valid_o && !w_ready_i) begin
                if (w_cnt == 0) w_cur = pick(w_cfg);
                if (w_cnt >= w_cur) w_ready_i = 1; else w_cnt++;
            end
            if (ar_valid_o && !ar_ready_i) begin
                if (ar_cnt == 0) ar_cur = pick(ar_cfg);
                if (ar_cnt >= ar_cur) ar_ready_i = 1; else ar_cnt++;
            end
            if (b_pend) begin
                if (b_cnt == 0) b_cur = pick(b_cfg);
                if (b_cnt >= b_cur) begin b_valid_i = 1; b_resp_i = b_resp_cfg; b_pend = 0; end
                else b_cnt++;
            end
            if (r_pend) begin
                if (r_cnt == 0) r_cur = pick(r_cfg);
                if (r_cnt >= r_cur) begin
                    r_valid_i = 1; r_data_i = mem[cap_araddr[10:3]]; r_resp_i = r_resp_cfg; r_pend = 0;
                end else r_cnt++;
            end
            aw_vq = aw_valid_o; p_aw_addr = aw_addr_o; p_aw_prot = aw_prot_o;
            w_vq = w_valid_o; p_w_data = w_data_o; p_w_strb = w_strb_o;
            ar_vq = ar_valid_o; p_ar_addr = ar_addr_o; p_ar_prot = ar_prot_o;
            b_hq = b_valid_i && b_ready_o;
            r_hq = r_valid_i && r_ready_o;
        end
    end

    // ---------------- APB master ----------------
    logic       aw_log [0:31];
    logic       w_log  [0:31];
    logic       br_log [0:31];
    logic [2:0] tb_prot = 3'b000;

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int cyc);
        psel_i = 1; penable_i = 0; pwrite_i = wr; paddr_i = addr;
        pwdata_i = data; pstrb_i = strb; pprot_i = tb_prot;
        @(negedge clk_i);
        penable_i = 1; cyc = 1;
        aw_log[1] = aw_valid_o; w_log[1] = w_valid_o; br_log[1] = b_ready_o;
        while (!pready_o) begin
            if (cyc >= 200) begin
                chk("apb_timeout", 0, 1);
                finish_sim();
            end
            @(negedge clk_i);
            cyc++;
            if (cyc < 32) begin
                aw_log[cyc] = aw_valid_o; w_log[cyc] = w_valid_o; br_log[cyc] = b_ready_o;
            end
        end
        rdata = prdata_o; err = pslverr_o;
        @(negedge clk_i);
        psel_i = 0; penable_i = 0;
        chk("pready_pulse", pready_o, 0);
    endtask

    task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic err, output int cyc);
        logic [31:0] rd;
        apb_xfer(1'b1, addr, data, strb, rd, err, cyc);
        for (int i = 0; i < 4; i++)
            if (strb[i]) ref_mem[addr[10:2]][8*i +: 8] = data[8*i +: 8];
    endtask

    task automatic apb_rd(input logic [31:0] addr, output logic [31:0] rdata,
                          output logic err, output int cyc);
        apb_xfer(1'b0, addr, 32'h0, 4'h0, rdata, err, cyc);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] rd, last_rd, addr, data;
        logic        err;
        int          cyc, idx;
        logic [3:0]  strb;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;

        repeat (3) @(negedge clk_i);
        rst_ni = 1;
        chk("rst_pready", pready_o, 0);
        chk("rst_pslverr", pslverr_o, 0);
        chk("rst_prdata", prdata_o, 0);
        chk("rst_valids", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o}, 0);
        chk("rst_payload", {aw_addr_o, aw_prot_o, w_strb_o}, 0);
        chk("rst_wdata", w_data_o, 0);

        // upper-lane write, everything ready at once
        tb_prot = 3'b010;
        apb_wr(32'h1A10_3004, 32'hDEADBEEF, 4'hF, err, cyc);
        chk("wr_lat", cyc, 3);
        chk("wr_err", err, 0);
        chk("wr_wdata", cap_wdata, 64'hDEADBEEF_DEADBEEF);
        chk("wr_wstrb", cap_wstrb, 8'hF0);
        chk("wr_awaddr", cap_awaddr, 32'h1A10_3004);
        chk("wr_awprot", cap_awprot, 3'b010);
        chk("wr_prdata_kept", prdata_o, 0);
        // lower-lane write
        apb_wr(32'h1A10_3000, 32'h12345678, 4'h3, err, cyc);
        chk("wr_lo_wstrb", cap_wstrb, 8'h03);

        // lane selection on read
        mem[0] = 64'h11112222_33334444;
        ref_mem[0] = 32'h33334444; ref_mem[1] = 32'h11112222;
        tb_prot = 3'b101;
        apb_rd(32'h1A10_4000, rd, err, cyc);
        chk("rd_lo", rd, 32'h33334444);
        chk("rd_lat", cyc, 3);
        chk("rd_err", err, 0);
        chk("rd_araddr", cap_araddr, 32'h1A10_4000);
        chk("rd_arprot", cap_arprot, 3'b101);
        apb_rd(32'h1A10_4004, rd, err, cyc);
        chk("rd_hi", rd, 32'h11112222);
        tb_prot = 3'b000;

        // AW held off 4 cycles, W 1 cycle
        aw_cfg = 4; w_cfg = 1;
        apb_wr(32'h1A10_5008, 32'h0BADF00D, 4'b1001, err, cyc);
        chk("dly_w_before", w_log[2], 1);
        chk("dly_w_dropped", w_log[3], 0);
        chk("dly_aw_held3", aw_log[3], 1);
        chk("dly_aw_held5", aw_log[5], 1);
        chk("dly_aw_dropped", aw_log[6], 0);
        chk("dly_bready_early", br_log[5], 0);
        chk("dly_bready", br_log[6], 1);
        chk("dly_lat", cyc, 7);
        chk("dly_prdata_kept", prdata_o, 32'h11112222);
        aw_cfg = 0; w_cfg = 0;
        apb_rd(32'h1A10_5008, rd, err, cyc);
        chk("dly_readback", rd, 32'h0B00000D);

        // error responses
        r_resp_cfg = 2'b11;
        apb_rd(32'h1A10_4000, rd, err, cyc);
        chk("rd_decerr", err, 1);
        r_resp_cfg = 2'b00;
        b_resp_cfg = 2'b00;
        apb_wr(32'h1A10_6000, 32'hCAFE0001, 4'hF, err, cyc);
        chk("wr_ok_after_err", err, 0);
        b_resp_cfg = 2'b01;
        apb_wr(32'h1A10_6004, 32'hCAFE0002, 4'hF, err, cyc);
        chk("wr_exokay", err, 0);
        b_resp_cfg = 2'b10;
        apb_wr(32'h1A10_6008, 32'hCAFE0003, 4'hF, err, cyc);
        chk("wr_slverr", err, 1);
        b_resp_cfg = 2'b00;

        // random backpressure against the word model
        rnd_mode = 1;
        last_rd = prdata_o;
        for (int n = 0; n < 1000; n++) begin
            idx  = int'($urandom_range(0, 511));
            addr = 32'h3000_0000 | (idx << 2);
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                apb_wr(addr, data, strb, err, cyc);
                chk("rnd_wr_err", err, 0);
                chk("rnd_wr_prdata", prdata_o, last_rd);
            end else begin
                apb_rd(addr, rd, err, cyc);
                chk("rnd_rd", rd, ref_mem[idx]);
                chk("rnd_rd_err", err, 0);
                last_rd = rd;
            end
        end
        rnd_mode = 0;

        // reset while waiting for B
        b_cfg = 40;
        psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = 32'h3000_07D0;
        pwdata_i = 32'hA5A5A5A5; pstrb_i = 4'hF;
        @(negedge clk_i);
        penable_i = 1;
        cyc = 0;
        while (!b_ready_o) begin
            if (cyc >= 20) begin
                chk("rst_wait_timeout", 0, 1);
                finish_sim();
            end
            @(negedge clk_i);
            cyc++;
        end
        rst_ni = 0;
        @(negedge clk_i);
        psel_i = 0; penable_i = 0;
        chk("midrst_outputs", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, pready_o}, 0);
        @(negedge clk_i);
        rst_ni = 1;
        b_cfg = 0;
        @(negedge clk_i);
        apb_rd(32'h3000_0000, rd, err, cyc);
        chk("post_rst_rd", rd, ref_mem[0]);
        chk("post_rst_lat", cyc, 3);

        finish_sim();
    end

endmodule
`default_nettype wire

// File: doc/apb2axi_lite_bridge.md
# apb2axi_lite_bridge

Reverse-direction bridge to the SoC's AXI-to-APB path: a 32-bit APB slave port (APB3/APB4 with PSTRB/PPROT) driven by an APB master such as a debug or host-control agent, converted to a 64-bit AXI4-Lite master port toward the SoC interconnect. It handles one transfer at a time. The APB access phase is stretched with `pready` until the AXI response returns. 32-bit APB data is steered onto the correct half of the 64-bit AXI data bus.

## Interface
- `ADDR_WIDTH`, default 32: APB and AXI address width.
- APB data width is fixed at 32 bits; AXI data width is fixed at 64 bits.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset. One clock; reset is synchronous and active-low.
- `psel_i`, `penable_i`, `pwrite_i`  in  1 each  APB control.
- `paddr_i`  in  ADDR_WIDTH  APB address.
- `pwdata_i`  in  32  APB write data.
- `pstrb_i`  in  4  APB byte strobes.
- `pprot_i`  in  3  APB protection.
- `pready_o`  out  1  APB ready.
- `prdata_o`  out  32  APB read data.
- `pslverr_o`  out  1  APB error.
- `aw_addr_o`  out  ADDR_WIDTH; `aw_prot_o`  out  3; `aw_valid_o`  out  1; `aw_ready_i`  in  1.
- `w_data_o`  out  64; `w_strb_o`  out  8; `w_valid_o`  out  1; `w_ready_i`  in  1.
- `b_resp_i`  in  2; `b_valid_i`  in  1; `b_ready_o`  out  1.
- `ar_addr_o`  out  ADDR_WIDTH; `ar_prot_o`  out  3; `ar_valid_o`  out  1; `ar_ready_i`  in  1.
- `r_data_i`  in  64; `r_resp_i`  in  2; `r_valid_i`  in  1; `r_ready_o`  out  1.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- **IDLE**
  - On `psel_i && !penable_i` (APB setup phase), latch `paddr`, `pwrite`, `pwdata`, `pstrb` and `pprot`.
  - Go to WR_REQ if `pwrite` is set, otherwise RD_REQ.
- **WR_REQ**
  - `aw_valid_o` and `w_valid_o` both assert on entry.
  - Each channel deasserts independently after its own handshake; two per-channel "sent" flags track this.
  - Go to WR_RESP once both handshakes are done. AW and W may complete in the same cycle or in either order.
- **WR_RESP**
  - `b_ready_o` = 1.
  - On `b_valid_i`, register `pslverr` = `b_resp_i[1]` (SLVERR and DECERR both map to error) and go to DONE.
- **RD_REQ**
  - `ar_valid_o` = 1 until `ar_ready_i`, then go to RD_RESP.
- **RD_RESP**
  - `r_ready_o` = 1.
  - On `r_valid_i`, register `prdata` = `paddr[2] ? r_data_i[63:32] : r_data_i[31:0]` and `pslverr` = `r_resp_i[1]`, then go to DONE.
- **DONE**
  - `pready_o` = 1 for exactly one cycle, then return to IDLE.
- Write lane steering:
  - `w_data_o` = {pwdata, pwdata}.
  - `w_strb_o` = `paddr[2]` ? {pstrb, 4'b0} : {4'b0, pstrb}.
- `aw_addr_o`/`ar_addr_o` carry the latched `paddr` unmodified. `aw_prot_o`/`ar_prot_o` carry the latched `pprot`.
- Latched request fields remain stable while the FSM is outside IDLE; any APB input changes during that time are ignored.
- AXI valids are never withdrawn before their handshake; all payload stays stable while valid is high.
- If `psel_i` drops before DONE (an APB violation), the AXI transaction still completes. The DONE pulse is still generated and ignored by the master. No new setup is accepted until the FSM returns to IDLE.
- `prdata_o` holds its value until the next completed read. On writes, `prdata_o` is unchanged.

## Timing
- Reset values: state IDLE; `pready_o` 0; `pslverr_o` 0; `prdata_o` 0; all AXI valid and ready outputs 0. AXI address, data, strobe and prot outputs reset to 0.
- `pready_o` and `pslverr_o` are registered, with no combinational path from AXI inputs. They are valid in the same cycle as each other.
- Minimum write, with ready signals tied high and `b_valid` one cycle after AW/W: setup T0, AW/W handshake T1, B handshake T2, `pready` T3. Three access-phase cycles.
- Minimum read follows the same pattern: setup T0, AR T1, R T2, `pready` T3.
- Back-to-back transfers: a setup phase can be accepted in the cycle after DONE.
- Reset mid-transaction: all valid and ready outputs drop in the cycle after reset is sampled and the FSM enters IDLE. The downstream AXI slave must share this reset.

## Test plan
- Write `paddr`=0x1A10_3004, `pwdata`=0xDEADBEEF, `pstrb`=0xF, all ready signals high, B=OKAY -> `w_data`=0xDEADBEEF_DEADBEEF, `w_strb`=0xF0, `pready` at T3, `pslverr`=0.
- Read `paddr`=0x1A10_4000 with `r_data`=0x11112222_33334444 -> `prdata`=0x33334444; the same read at 0x...4004 -> `prdata`=0x11112222.
- Write with `aw_ready` delayed 4 cycles and `w_ready` delayed 1 cycle -> W drops after its own handshake, AW holds until cycle 4, `b_ready` rises only after both handshakes.
- Read with `r_resp`=2'b11 -> `pslverr`=1 with `pready`; a following write with B=OKAY -> `pslverr`=0.
- Random ready/valid backpressure over 1000 transfers -> AXI payload stable while valid is high, exactly one `pready` pulse per APB access, read data matches a memory model.
- `rst_ni` low while in WR_RESP -> all valids and readies are 0 on the next cycle, and a subsequent read completes normally.
